uart_transmit: RTL and testbench

UART_TRANSMIT -- requirements
Module: uart_transmit

---
 rtl/uart_transmit_if.sv | 24 ++
 rtl/uart_transmit.sv | 141 ++++++++++++++
 tb/tb_uart_transmit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmit_if.sv
// Byte-in / serial-out bundle of the buffered UART transmitter.
// The slave side is the transmitter; the master side feeds bytes and watches the line.
interface uart_transmit_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       data_byte_in;
  logic             valid_in;
  logic             ready_out;
  logic             tx_wire_out;
  logic             busy_out;
  logic [CNT_W-1:0] count_out;

  modport slave (
    input  data_byte_in, valid_in,
    output ready_out, tx_wire_out, busy_out, count_out
  );

  modport master (
    output data_byte_in, valid_in,
    input  ready_out, tx_wire_out, busy_out, count_out
  );
endinterface

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter fed by a small circular FIFO.
// Frames run back-to-back with no idle gap while bytes are buffered.
module uart_transmit #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic           clk_in,
  input  logic           rst_in,
  uart_transmit_if.slave bus
);
  localparam int BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic              push, pop, fifo_empty, bit_done;

  assign fifo_empty      = (count_q == '0);
  assign bus.ready_out   = (count_q != CNT_FULL);
  assign push            = bus.valid_in && bus.ready_out;
  assign bit_done        = (baud_q == BAUD_LAST);
  assign bus.tx_wire_out = tx_q;
  assign bus.busy_out    = (state_q != IDLE) || !fifo_empty;
  assign bus.count_out   = count_q;

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.data_byte_in;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    if (state_q != IDLE) begin
      baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
    end
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          bit_d   = '0;
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_d = '0;
          // A waiting byte starts its start bit right after this stop bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: cycle-level frame-timer model plus directed line decoding.
// Inputs change on the falling edge; outputs are checked 1 time unit after each rising edge.
module tb_uart_transmit;
  localparam int CLK_HZ = 160;
  localparam int BAUD   = 10;
  localparam int DEPTH  = 4;
  localparam int BP     = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * BP;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;

  uart_transmit_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_transmit #(
    .INPUT_CLOCK_FREQ(CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=0x%0h required=0x%0h", name, $time, got, exp);
    end
  endtask

  // Reference: a queue of accepted bytes and a countdown of the frame on the line.
  logic [7:0] m_fifo[$];
  int         m_timer  = 0;
  logic [9:0] m_frame  = '1;
  bit         m_accept = 0;

  initial begin : model
    bit         pop, push;
    logic [7:0] head;
    logic       exp_tx;
    forever begin
      @(posedge clk_in or posedge rst_in);
      if (rst_in) begin
        m_fifo.delete();
        m_timer  = 0;
        m_accept = 0;
      end else begin
        pop  = (m_fifo.size() != 0) && (m_timer <= 1);
        push = bus.valid_in && (m_fifo.size() != DEPTH);
        if (pop) begin
          head    = m_fifo.pop_front();
          m_frame = {1'b1, head, 1'b0};
          m_timer = FRAME;
        end else if (m_timer > 0) begin
          m_timer--;
        end
        if (push) m_fifo.push_back(bus.data_byte_in);
        m_accept = push;
      end
      #1;
      exp_tx = (m_timer == 0) ? 1'b1 : m_frame[(FRAME - m_timer) / BP];
      check("outputs{tx,rdy,busy,cnt}",
            {bus.tx_wire_out, bus.ready_out, bus.busy_out, bus.count_out},
            {exp_tx, (m_fifo.size() != DEPTH), (m_timer != 0 || m_fifo.size() != 0),
             3'(m_fifo.size())});
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // {stop, d7..d0, start}
  } vec_t;

  vec_t        vecs[4];
  logic [29:0] line_bits;

  task automatic send_one(input logic [7:0] d);
    @(negedge clk_in);
    bus.valid_in     = 1'b1;
    bus.data_byte_in = d;
    @(negedge clk_in);
    bus.valid_in     = 1'b0;
  endtask

  // Samples the middle of nbits consecutive bit periods, the first after first_wait falling edges.
  task automatic sample_bits(input int first_wait, input int nbits);
    line_bits = '0;
    repeat (first_wait) @(negedge clk_in);
    line_bits[0] = bus.tx_wire_out;
    for (int b = 1; b < nbits; b++) begin
      repeat (BP) @(negedge clk_in);
      line_bits[b] = bus.tx_wire_out;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_timer != 0 || m_fifo.size() != 0) && n < 4000) begin
      @(negedge clk_in);
      n++;
    end
    check("drain_in_time", 32'(n < 4000), 32'd1);
    repeat (3) @(negedge clk_in);
  endtask

  // Holds valid_in high, advancing the byte only when it has been accepted.
  task automatic stream(input int n, input bit rnd);
    int         idx      = 0;
    int         guard    = 0;
    bit         seen_full = 0;
    logic [2:0] max_cnt  = '0;
    @(negedge clk_in);
    bus.valid_in     = 1'b1;
    bus.data_byte_in = rnd ? 8'($urandom) : 8'h11;
    while (idx < n && guard < 4000) begin
      @(negedge clk_in);
      guard++;
      if (bus.count_out > max_cnt) max_cnt = bus.count_out;
      if (m_fifo.size() == DEPTH && !seen_full) begin
        seen_full = 1;
        check("ready_low_when_full", 32'(bus.ready_out), 32'd0);
      end
      if (m_accept) begin
        idx++;
        if (idx < n) bus.data_byte_in = rnd ? 8'($urandom) : 8'(8'h11 * (idx + 1));
        else         bus.valid_in = 1'b0;
      end
    end
    bus.valid_in = 1'b0;
    check("stream_accepted", 32'(idx), 32'(n));
    check("stream_reached_full", 32'(seen_full), 32'd1);
    check("stream_count_max", 32'(max_cnt), 32'(DEPTH));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1);
  end

  initial begin : main
    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{data: 8'h5A, line: 10'b1010110100};

    // Bytes offered during reset must be ignored.
    bus.valid_in     = 1'b1;
    bus.data_byte_in = 8'h77;
    repeat (4) @(negedge clk_in);
    check("rst_count", 32'(bus.count_out), 32'd0);
    bus.valid_in = 1'b0;
    rst_in       = 1'b0;
    repeat (3) @(negedge clk_in);
    check("idle_line", 32'(bus.tx_wire_out), 32'd1);
    check("idle_busy", 32'(bus.busy_out), 32'd0);

    for (int i = 0; i < 4; i++) begin
      send_one(vecs[i].data);
      sample_bits(8, 10);
      check("table_line", 32'(line_bits[9:0]), 32'(vecs[i].line));
      wait_idle();
    end

    // Three bytes back-to-back: 30 contiguous bit periods.
    @(negedge clk_in);
    bus.valid_in = 1'b1; bus.data_byte_in = 8'h00;
    @(negedge clk_in); bus.data_byte_in = 8'hFF;
    @(negedge clk_in); bus.data_byte_in = 8'h3C;
    @(negedge clk_in); bus.valid_in = 1'b0;
    sample_bits(6, 30);
    check("b2b_line", 32'(line_bits), {2'b00, 10'b1001111000, 10'b1111111110, 10'b1000000000});
    wait_idle();

    stream(6, 1'b0);
    wait_idle();

    // Reset in the middle of data bit 3 with two bytes buffered.
    @(negedge clk_in);
    bus.valid_in = 1'b1; bus.data_byte_in = 8'hC3;
    @(negedge clk_in); bus.data_byte_in = 8'h12;
    @(negedge clk_in); bus.data_byte_in = 8'h34;
    @(negedge clk_in); bus.valid_in = 1'b0;
    repeat (70) @(negedge clk_in);
    check("pre_rst_count", 32'(bus.count_out), 32'd2);
    rst_in = 1'b1;
    #1;
    check("async_rst_tx", 32'(bus.tx_wire_out), 32'd1);
    check("async_rst_count", 32'(bus.count_out), 32'd0);
    check("async_rst_ready", 32'(bus.ready_out), 32'd1);
    check("async_rst_busy", 32'(bus.busy_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    send_one(8'h81);
    sample_bits(8, 10);
    check("post_rst_line", 32'(line_bits[9:0]), 32'(10'b1100000010));
    wait_idle();

    // Ten random bytes streamed continuously across the pointer wrap.
    stream(10, 1'b1);
    wait_idle();

    // Sparse random traffic.
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk_in);
      bus.valid_in     = ($urandom_range(0, 39) == 0);
      bus.data_byte_in = 8'($urandom);
    end
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
